// File: rtl/tetris_pkg.sv
// Shared types and helpers for the Tetris line-clear datapath.
// Optional build macro: LINE_CLEAR_BONUS_EN selects the classic bonus score table;
// when undefined, the score increment equals the number of lines cleared.
package tetris_pkg;

    localparam int unsigned DEF_COLS   = 10;
    localparam int unsigned DEF_ROWS   = 20;
    localparam int unsigned BOARD_BITS = DEF_COLS * DEF_ROWS;
    localparam int unsigned ROW_W      = 5;
    localparam int unsigned SCORE_W    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } clear_state_t;

    // Maps a cleared-line count to a score increment, saturating at 127.
    function automatic logic [SCORE_W-1:0] score_of(input logic [ROW_W-1:0] n);
        logic [SCORE_W-1:0] score;
`ifdef LINE_CLEAR_BONUS_EN
        logic [7:0] wide;
        case (n)
            5'd0:    wide = 8'd0;
            5'd1:    wide = 8'd1;
            5'd2:    wide = 8'd3;
            5'd3:    wide = 8'd5;
            5'd4:    wide = 8'd8;
            default: wide = 8'd8 + {2'b00, n - 5'd4, 1'b0};
        endcase
        score = (wide > 8'd127) ? 7'd127 : wide[6:0];
`else
        score = {2'b00, n};
`endif
        return score;
    endfunction

endpackage

// File: rtl/line_score_map.sv
// Combinational lines-cleared to score-increment mapping.
// Behaviour depends on LINE_CLEAR_BONUS_EN through tetris_pkg::score_of.
module line_score_map
    import tetris_pkg::*;
(
    input  logic [ROW_W-1:0]   lines_cleared,
    output logic [SCORE_W-1:0] score_add
);

    // Pure table lookup; no state.
    always_comb begin
        score_add = score_of(lines_cleared);
    end

endmodule

// File: rtl/line_clear_sequencer.sv
// Line-clear sequencer: scans a locked playfield bottom-up, removes full rows one
// per cycle and compacts the rest downward, then reports lines and score.
// Optional build macro: LINE_CLEAR_BONUS_EN (handled inside line_score_map).
module line_clear_sequencer
    import tetris_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COLS*ROWS-1:0]   board_in,
    output logic                   busy,
    output logic                   done,
    output logic [COLS*ROWS-1:0]   board_out,
    output logic [ROW_W-1:0]       lines_cleared,
    output logic [SCORE_W-1:0]     score_add
);

    localparam int unsigned BITS = COLS * ROWS;

    clear_state_t         state, state_n;
    logic [BITS-1:0]      board, board_n;
    logic [ROW_W-1:0]     ptr, ptr_n;
    logic [ROW_W-1:0]     cnt, cnt_n;
    logic                 load_out;
    logic                 row_full;
    logic [BITS-1:0]      shifted_board;
    logic [SCORE_W-1:0]   score_calc;

    line_score_map u_score_map (
        .lines_cleared (cnt),
        .score_add     (score_calc)
    );

    // Row fullness test and the single-cycle shift of rows 0..ptr down by one row.
    always_comb begin
        logic [BITS-1:0]  all_ones;
        logic [BITS-1:0]  low_mask;
        int unsigned      row_base;
        int unsigned      shamt;
        all_ones = '1;
        row_base = 32'(ptr) * COLS;
        row_full = (board[row_base +: COLS] == {COLS{1'b1}});
        // low_mask covers rows 0..ptr; rows below ptr keep their contents.
        shamt         = (32'(ptr) + 32'd1) * COLS;
        low_mask      = ~(all_ones << shamt);
        shifted_board = ((board << COLS) & low_mask) | (board & ~low_mask);
    end

    // Next-state and datapath control.
    always_comb begin
        state_n  = state;
        board_n  = board;
        ptr_n    = ptr;
        cnt_n    = cnt;
        load_out = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    board_n = board_in;
                    ptr_n   = ROW_W'(ROWS - 1);
                    cnt_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_n = SHIFT;
                end else if (ptr == '0) begin
                    state_n  = DONE;
                    load_out = 1'b1;
                end else begin
                    ptr_n = ptr - 1'b1;
                end
            end
            SHIFT: begin
                board_n = shifted_board;
                cnt_n   = cnt + 1'b1;
                state_n = SCAN;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state == SCAN) || (state == SHIFT);
        done = (state == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Working board, row pointer and line counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            board <= board_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    // Result registers are loaded on entry to DONE so they are valid with the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board_out     <= '0;
            lines_cleared <= '0;
            score_add     <= '0;
        end else if (load_out) begin
            board_out     <= board;
            lines_cleared <= cnt;
            score_add     <= score_calc;
        end
    end

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Randomized self-checking bench for line_clear_sequencer against a row-list model.
module tb_line_clear_sequencer;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int BITS = COLS * ROWS;

    logic            clk;
    logic            rst;
    logic            start;
    logic [BITS-1:0] board_in;
    logic            busy;
    logic            done;
    logic [BITS-1:0] board_out;
    logic [4:0]      lines_cleared;
    logic [6:0]      score_add;

    int checks;
    int failures;

    line_clear_sequencer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .score_add     (score_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: keep non-full rows in bottom-up order, stack them at the bottom.
    function automatic void model(input logic [BITS-1:0] b, output logic [BITS-1:0] o, output int k);
        logic [COLS-1:0] row;
        int dst;
        o   = '0;
        k   = 0;
        dst = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = b[r*COLS +: COLS];
            if (row == {COLS{1'b1}}) begin
                k++;
            end else begin
                o[dst*COLS +: COLS] = row;
                dst--;
            end
        end
    endfunction

    function automatic int exp_score(input int k);
`ifdef LINE_CLEAR_BONUS_EN
        int s;
        case (k)
            0: s = 0;
            1: s = 1;
            2: s = 3;
            3: s = 5;
            4: s = 8;
            default: s = 8 + 2 * (k - 4);
        endcase
        return (s > 127) ? 127 : s;
`else
        return k;
`endif
    endfunction

    task automatic run_op(input string name, input logic [BITS-1:0] b, input bit repulse);
        logic [BITS-1:0] exp_board;
        int              k;
        int              lat;
        int              n;
        bit              seen;
        bit              busy_ok;
        model(b, exp_board, k);
        lat     = ROWS + 2 * k;
        seen    = 1'b0;
        busy_ok = 1'b1;
        n       = 0;
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        board_in = '0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (repulse && n == 4) begin
                start    = 1'b1;
                board_in = ~b;
            end
            if (repulse && n == 5) begin
                start    = 1'b0;
                board_in = '0;
            end
            if (done) begin
                seen = 1'b1;
                if (busy) busy_ok = 1'b0;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        check({name, "_done_seen"}, 256'(seen), 256'(1));
        check({name, "_latency"}, 256'(n), 256'(lat));
        check({name, "_busy"}, 256'(busy_ok), 256'(1));
        check({name, "_board"}, 256'(board_out), 256'(exp_board));
        check({name, "_lines"}, 256'(lines_cleared), 256'(k));
        check({name, "_score"}, 256'(score_add), 256'(exp_score(k)));
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 256'({done, busy}), 256'(0));
        check({name, "_hold"}, 256'(board_out), 256'(exp_board));
    endtask

    initial begin
        logic [BITS-1:0] b;
        logic [BITS-1:0] one;
        bit              saw_done;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        board_in = '0;
        one      = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 256'({busy, done, board_out, lines_cleared, score_add}), 256'(0));
        @(negedge clk);
        rst = 1'b1;

        run_op("empty", '0, 1'b0);

        b = '0;
        b[19*COLS +: COLS] = '1;
        b[18*COLS + 3] = 1'b1;
        run_op("one_line", b, 1'b0);
        check("one_line_bit", 256'(board_out), 256'(one << (19*COLS + 3)));

        b = '0;
        for (int r = 16; r < 20; r++) b[r*COLS +: COLS] = '1;
        b[15*COLS] = 1'b1;
        run_op("tetris", b, 1'b0);

        b = '0;
        b[19*COLS +: COLS] = '1;
        b[17*COLS +: COLS] = '1;
        b[18*COLS +: COLS] = 10'h001;
        b[16*COLS +: COLS] = 10'h200;
        run_op("split", b, 1'b0);

        run_op("all_full", '1, 1'b0);

        b = '0;
        b[19*COLS +: COLS] = '1;
        b[5*COLS +: COLS]  = 10'h155;
        run_op("repulse", b, 1'b1);

        // Abort mid-operation with an asynchronous reset.
        b = '1;
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_outputs", 256'({busy, done, board_out, lines_cleared, score_add}), 256'(0));
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 256'(saw_done), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        b = '0;
        b[10*COLS +: COLS] = '1;
        b[3*COLS + 7] = 1'b1;
        run_op("after_abort", b, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(2) == 0) b[r*COLS +: COLS] = '1;
                else b[r*COLS +: COLS] = 10'($urandom);
            end
            run_op($sformatf("rand%0d", t), b, 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_clear_sequencer.md
Name: line_clear_sequencer

Overview:
- Multi-cycle sequencer that takes a settled Tetris playfield from the game controller after a piece locks.
- Removes every full row and compacts the remaining rows downward.
- Reports the number of lines cleared and the score increment.
- Sits between the piece-lock logic and the score/board registers of the game controller; one row-operation per clock keeps the 200-bit datapath shallow.

Parameters:
- COLS, 10, playfield width in cells.
- ROWS, 20, playfield height in cells; board width is COLS*ROWS.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request pulse; board_in sampled on the same edge
- board_in  input  COLS*ROWS  playfield; cell (row r, col c) at bit r*COLS+c; row 0 = top, row ROWS-1 = bottom; 1 = occupied
- busy  output  1  high while a clear operation is in progress
- done  output  1  one-cycle pulse when results are valid
- board_out  output  COLS*ROWS  compacted playfield, same layout
- lines_cleared  output  5  full rows removed by the last operation, 0..ROWS
- score_add  output  7  score increment for the last operation

Behaviour:
- Reset (rst low, async): state IDLE. busy, done, board_out, lines_cleared and score_add all 0.
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - On start=1: latch board_in into the working board, row pointer := ROWS-1, line counter := 0, busy := 1, next state SCAN.
  - start in any other state is ignored and not queued.
- SCAN (one row per cycle):
  - Pointed row all ones: next state SHIFT, pointer unchanged.
  - Otherwise, pointer = 0: next state DONE.
  - Otherwise: pointer decrements, stay in SCAN.
- SHIFT (one cycle):
  - Rows 0..p-1 move to rows 1..p; row 0 becomes all zeros; line counter +1.
  - Return to SCAN at the same p, so row p is re-checked after the shift.
- DONE (one cycle):
  - board_out := working board; lines_cleared := counter; score_add := mapped score.
  - done = 1, busy = 0.
  - Next state IDLE.
- Outputs hold until the next DONE or reset. done is low in every state except DONE.
- Latency, with k full rows: done is high exactly 20+2k edges after the edge that sampled start (ROWS+2k generally). Worst case k=ROWS gives 60 edges.
- An all-full board clears to all zeros with lines_cleared=20. Row 0 is refilled with zeros, so the scan always terminates.
- A start in the same cycle as DONE is ignored; start is accepted only when state is IDLE.
- Reset mid-operation aborts immediately. The partial board is discarded and no done pulse is generated.
- Arithmetic:
  - Counter is 5 bits and cannot overflow (max 20).
  - score_add is computed at 7 bits and saturates at 127.

Optional Feature:
- LINE_CLEAR_BONUS_EN defined:
  - score_add uses the classic table: 0→0, 1→1, 2→3, 3→5, 4→8.
  - For n>4: 8+2*(n-4), saturating at 127.
- Not defined: score_add = lines_cleared, zero-extended to 7 bits.

Decomposition:
- Package tetris_pkg:
  - COLS/ROWS defaults, BOARD_BITS.
  - Row-index width (5).
  - State enum {IDLE, SCAN, SHIFT, DONE}.
  - Score mapping function (bonus table guarded by LINE_CLEAR_BONUS_EN).
- Sub-module line_score_map: combinational, lines_cleared → score_add. Isolates the macro-dependent logic so the FSM is unaffected.

Test Plan:
- Empty board, start pulse → done after 20 edges; board_out=0; lines_cleared=0; score_add=0; busy high for 20 cycles.
- Row 19 full, plus bit at (18,3) → done after 22 edges; board_out has only bit (19,3) set; lines_cleared=1; score_add=1.
- Rows 16–19 full, bit (15,0) set → done after 28 edges; board_out has only bit (19,0) set; lines_cleared=4. score_add=8 with LINE_CLEAR_BONUS_EN, 4 without.
- Non-adjacent full rows 17 and 19, row 18 = 0x001, row 16 = 0x200 → board_out row 19 = 0x001, row 18 = 0x200, all other rows 0; lines_cleared=2; score_add=3 (bonus) / 2 (plain).
- start re-pulsed at cycle 5 while busy → ignored; single done pulse; results match the first board only.
- rst low at cycle 10 of an operation → all outputs 0 within that cycle; no done pulse. A fresh start after release completes normally.
